exu_issue: RTL and testbench
============================

Name: exu_issue

Overview:
- Execute-stage issue/collect controller. It is the initiator side of the hs_ex4cal/hs_cal4ex handshake.
- Accepts one decoded ALU operation from decode, holds it, and drives it to the calculation unit until that unit is ready.
- Captures the combinational result in the handshake cycle and presents it to writeback with its own valid/ready handshake.
- Supports pipeline flush and keeps a saturating stall-cycle counter for performance monitoring.

Parameters:
- OPB_W, default `CIRNO_CAL_OPB_SIZE (cirno9_define.v): width of the calculation operand/opcode bundle.
- CNT_W, default 16: width of the stall-cycle counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- hs_de4ex_val  input  1  decode presents an operation.
- hs_ex4de_rdy  output  1  this block accepts an operation this cycle.
- i_opb  input  OPB_W  operation bundle from decode.
- i_rd  input  5  destination register index.
- i_rd_wen  input  1  destination write enable.
- hs_ex4cal_val  output  1  operation valid to calculation unit.
- hs_cal4ex_rdy  input  1  calculation unit ready.
- o_cal_opb  output  OPB_W  held operation bundle to calculation unit.
- i_cal_res  input  32  calculation result; sampled only when hs_ex4cal_val & hs_cal4ex_rdy.
- hs_ex4wb_val  output  1  result valid to writeback.
- hs_wb4ex_rdy  input  1  writeback ready.
- o_wb_rd  output  5  destination index.
- o_wb_wen  output  1  destination write enable.
- o_wb_data  output  32  captured result.
- i_flush  input  1  kill any in-flight operation.
- o_stall_cnt  output  CNT_W  saturating count of stall cycles.

Behaviour:
- States: IDLE, ISS, WB. On reset: state IDLE; opb/rd/wen/result registers 0; o_stall_cnt 0; all valid outputs 0.
- IDLE:
  - hs_ex4de_rdy = ~i_flush.
  - On hs_de4ex_val & hs_ex4de_rdy: latch i_opb, i_rd, i_rd_wen; go to ISS.
- ISS:
  - hs_ex4cal_val = ~i_flush; o_cal_opb = latched bundle; hs_ex4de_rdy = 0.
  - On hs_ex4cal_val & hs_cal4ex_rdy: capture i_cal_res into the result register; go to WB.
  - Otherwise stay in ISS with the bundle held stable.
- WB:
  - hs_ex4wb_val = ~i_flush; outputs are driven from registers.
  - hs_ex4de_rdy = hs_wb4ex_rdy & ~i_flush.
  - On wb handshake with a simultaneous decode handshake: latch the new operation and go to ISS (back-to-back).
  - On wb handshake alone: go to IDLE.
  - Otherwise hold all outputs stable.
- o_cal_opb equals the latched bundle in every state. Only hs_ex4cal_val qualifies it.
- o_wb_wen is registered as i_rd_wen & (i_rd != 0). An x0 destination never produces a write.
- Latency: decode accept at edge N; hs_ex4cal_val high in cycle N+1; with hs_cal4ex_rdy=1, hs_ex4wb_val high in cycle N+2. Peak throughput is one operation per 2 cycles.
- Flush:
  - i_flush has priority over every handshake. In the flush cycle all three valid/ready outputs of this block are forced 0 combinationally, so no handshake can complete.
  - The next state is IDLE and the held operation is discarded.
  - The result register is not cleared, but it is never presented.
- Stall counter:
  - Increments by 1 in any cycle where (state ISS & ~hs_cal4ex_rdy) or (state WB & ~hs_wb4ex_rdy), excluding flush cycles.
  - Saturates at all-ones.
  - Cleared only by rst.
- Reset mid-operation: rst has priority over flush and handshakes. The next cycle is IDLE with all outputs at their reset values.
- No combinational path from hs_cal4ex_rdy to hs_ex4cal_val. hs_wb4ex_rdy → hs_ex4de_rdy is the only input-to-ready path.

Test Plan:
- ADD, opn1=5, opn2=7, rd=3, wen=1, cal_rdy=1, wb_rdy=1. Expected: cal_val in cycle N+1; wb_val in cycle N+2 with data=12, rd=3, wen=1; state IDLE in N+3.
- cal_rdy held 0 for 3 cycles, then 1 (opn1=0xFFFFFFFF, opn2=1, ADD). Expected: o_cal_opb stable throughout; o_stall_cnt=3; wb data=0x00000000.
- wb_rdy held 0 for 2 cycles. Expected: wb_val, wb_data and wb_rd held stable; counter +2; de_rdy=0 until the wb handshake.
- Back-to-back: op A (rd=1) in WB with wb_rdy=1 and op B presented. Expected: B accepted in the same cycle as A retires; B's cal_val in the next cycle.
- rd=0, wen=1. Expected: o_wb_wen=0 and data still presented.
- i_flush while in ISS with cal_rdy=1. Expected: cal_val=0 that cycle; no WB; IDLE next cycle; de_rdy=1 again. With CNT_W=4 and 20 stall cycles, o_stall_cnt saturates at 15.

Source files
------------

// File: rtl/exu_issue.sv
// ---------------------------------------------------------------------------
// exu_issue -- execute-stage issue/collect controller
//
// Takes one decoded ALU operation from decode, holds it and offers it to the
// calculation unit until that unit is ready, captures the combinational
// result in the handshake cycle and offers it to writeback.  A flush kills any
// in-flight operation.  A saturating counter records cycles in which a held
// operation waited on the calculation unit or on writeback.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   hs_de4ex_val / hs_ex4de_rdy  decode -> exu handshake
//   i_opb, i_rd, i_rd_wen        operation bundle and destination from decode
//   hs_ex4cal_val / hs_cal4ex_rdy exu -> calculation unit handshake
//   o_cal_opb                    held operation bundle
//   i_cal_res                    calculation result (sampled on cal handshake)
//   hs_ex4wb_val / hs_wb4ex_rdy  exu -> writeback handshake
//   o_wb_rd, o_wb_wen, o_wb_data destination and captured result
//   i_flush                      kill in-flight operation, blocks all handshakes
//   o_stall_cnt                  saturating stall-cycle counter
// ---------------------------------------------------------------------------

// The bundle width normally comes from the project-wide define file; this
// fallback keeps the block self-contained: {opcode[5:0], opn1[31:0], opn2[31:0]}.
`ifndef CIRNO_CAL_OPB_SIZE
`define CIRNO_CAL_OPB_SIZE 70
`endif

module exu_issue #(
    parameter int OPB_W = `CIRNO_CAL_OPB_SIZE,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hs_de4ex_val,
    output logic             hs_ex4de_rdy,
    input  logic [OPB_W-1:0] i_opb,
    input  logic [4:0]       i_rd,
    input  logic             i_rd_wen,
    output logic             hs_ex4cal_val,
    input  logic             hs_cal4ex_rdy,
    output logic [OPB_W-1:0] o_cal_opb,
    input  logic [31:0]      i_cal_res,
    output logic             hs_ex4wb_val,
    input  logic             hs_wb4ex_rdy,
    output logic [4:0]       o_wb_rd,
    output logic             o_wb_wen,
    output logic [31:0]      o_wb_data,
    input  logic             i_flush,
    output logic [CNT_W-1:0] o_stall_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ISS  = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic [OPB_W-1:0] r_opb;
    logic [4:0]       r_rd;
    logic             r_wen;
    logic [31:0]      r_res;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_de_rdy;
    logic w_cal_val;
    logic w_wb_val;
    logic w_de_hs;
    logic w_cal_hs;
    logic w_wb_hs;
    logic w_stall;

    // Handshake qualifiers.  Valids depend only on state and flush, so there
    // is no path from either ready input back to a valid; the single
    // input-to-ready path is hs_wb4ex_rdy -> hs_ex4de_rdy in WB, which lets a
    // new operation enter in the same cycle the previous one retires.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // through the case leaves it unassigned, which would infer a latch.
        w_de_rdy  = 1'b0;
        w_cal_val = 1'b0;
        w_wb_val  = 1'b0;
        w_stall   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_de_rdy = ~i_flush;
            end
            ST_ISS: begin
                w_cal_val = ~i_flush;
                w_stall   = ~i_flush & ~hs_cal4ex_rdy;
            end
            ST_WB: begin
                w_wb_val = ~i_flush;
                w_de_rdy = hs_wb4ex_rdy & ~i_flush;
                w_stall  = ~i_flush & ~hs_wb4ex_rdy;
            end
            default: begin
                w_de_rdy = 1'b0;
            end
        endcase
    end

    assign w_de_hs  = hs_de4ex_val & w_de_rdy;
    assign w_cal_hs = w_cal_val & hs_cal4ex_rdy;
    assign w_wb_hs  = w_wb_val & hs_wb4ex_rdy;

    // State, operation holding registers, result capture and stall counter.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every register samples pre-edge values regardless of statement order.
        if (rst) begin
            r_state     <= ST_IDLE;
            r_opb       <= '0;
            r_rd        <= '0;
            r_wen       <= 1'b0;
            r_res       <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end

            if (i_flush) begin
                // Held operation is abandoned; the result register keeps its
                // stale value but is never presented outside WB.
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_de_hs) begin
                            r_opb   <= i_opb;
                            r_rd    <= i_rd;
                            r_wen   <= i_rd_wen & (i_rd != 5'd0);
                            r_state <= ST_ISS;
                        end
                    end
                    ST_ISS: begin
                        if (w_cal_hs) begin
                            r_res   <= i_cal_res;
                            r_state <= ST_WB;
                        end
                    end
                    ST_WB: begin
                        if (w_wb_hs) begin
                            if (w_de_hs) begin
                                // Back-to-back: next op enters as this retires.
                                r_opb   <= i_opb;
                                r_rd    <= i_rd;
                                r_wen   <= i_rd_wen & (i_rd != 5'd0);
                                r_state <= ST_ISS;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign hs_ex4de_rdy  = w_de_rdy;
    assign hs_ex4cal_val = w_cal_val;
    assign hs_ex4wb_val  = w_wb_val;
    assign o_cal_opb     = r_opb;
    assign o_wb_rd       = r_rd;
    assign o_wb_wen      = r_wen;
    assign o_wb_data     = r_res;
    assign o_stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_exu_issue.sv
// ---------------------------------------------------------------------------
// tb_exu_issue -- self-checking bench for exu_issue.
// The bench plays decode, the calculation unit and writeback.  Bundle layout
// used here: {opcode[5:0], opn1[31:0], opn2[31:0]}; opcode 0=ADD 1=SUB 2=XOR
// 3=AND.  Inputs change 1 time unit after the rising edge, outputs are
// sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_exu_issue;

    localparam int OPB_W = 70;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             de_val;
    logic             de_rdy;
    logic [OPB_W-1:0] opb;
    logic [4:0]       rd;
    logic             rd_wen;
    logic             cal_val;
    logic             cal_rdy;
    logic [OPB_W-1:0] cal_opb;
    logic [31:0]      cal_res;
    logic             wb_val;
    logic             wb_rdy;
    logic [4:0]       wb_rd;
    logic             wb_wen;
    logic [31:0]      wb_data;
    logic             flush;
    logic [CNT_W-1:0] stall_cnt;
    logic [31:0]      noise;

    int n_cmp = 0;
    int n_err = 0;

    exu_issue #(.OPB_W(OPB_W), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .hs_de4ex_val  (de_val),
        .hs_ex4de_rdy  (de_rdy),
        .i_opb         (opb),
        .i_rd          (rd),
        .i_rd_wen      (rd_wen),
        .hs_ex4cal_val (cal_val),
        .hs_cal4ex_rdy (cal_rdy),
        .o_cal_opb     (cal_opb),
        .i_cal_res     (cal_res),
        .hs_ex4wb_val  (wb_val),
        .hs_wb4ex_rdy  (wb_rdy),
        .o_wb_rd       (wb_rd),
        .o_wb_wen      (wb_wen),
        .o_wb_data     (wb_data),
        .i_flush       (flush),
        .o_stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [OPB_W-1:0] mk(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        return {op, a, b};
    endfunction

    function automatic logic [31:0] calc(input logic [OPB_W-1:0] p);
        logic [31:0] a;
        logic [31:0] b;
        a = p[63:32];
        b = p[31:0];
        case (p[69:64])
            6'd0:    return a + b;
            6'd1:    return a - b;
            6'd2:    return a ^ b;
            default: return a & b;
        endcase
    endfunction

    // Calculation unit model: a real answer only in the handshake cycle,
    // garbage otherwise, so a mistimed capture shows up as wrong data.
    always @(posedge clk) noise <= $urandom;
    assign cal_res = (cal_val && cal_rdy) ? calc(cal_opb) : noise;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; de_val = 1'b0; cal_rdy = 1'b0; wb_rdy = 1'b0; flush = 1'b0;
        opb = '0; rd = '0; rd_wen = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_cmp++; if (de_rdy !== 1'b1)  begin n_err++; $display("FAIL reset_de_rdy: got %b want 1", de_rdy); end
        n_cmp++; if (cal_val !== 1'b0) begin n_err++; $display("FAIL reset_cal_val: got %b want 0", cal_val); end
        n_cmp++; if (wb_val !== 1'b0)  begin n_err++; $display("FAIL reset_wb_val: got %b want 0", wb_val); end
        n_cmp++; if ({cal_opb, wb_rd, wb_wen, wb_data} !== '0) begin n_err++; $display("FAIL reset_regs: got opb=%h rd=%0d wen=%b data=%h want all 0", cal_opb, wb_rd, wb_wen, wb_data); end
        n_cmp++; if (stall_cnt !== 4'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt); end
        tick();
    endtask

    task automatic test_basic_add();
        do_reset();
        de_val = 1'b1; opb = mk(6'd0, 32'd5, 32'd7); rd = 5'd3; rd_wen = 1'b1; cal_rdy = 1'b1; wb_rdy = 1'b1;
        @(negedge clk);
        n_cmp++; if (de_rdy !== 1'b1) begin n_err++; $display("FAIL add_accept: got de_rdy=%b want 1", de_rdy); end
        tick();
        de_val = 1'b0; opb = mk(6'd3, $urandom, $urandom); rd = 5'd9;
        @(negedge clk);
        n_cmp++; if (cal_val !== 1'b1 || wb_val !== 1'b0) begin n_err++; $display("FAIL add_n1_cal: got cal_val=%b wb_val=%b want 1/0", cal_val, wb_val); end
        n_cmp++; if (cal_opb !== mk(6'd0, 32'd5, 32'd7)) begin n_err++; $display("FAIL add_n1_opb: got %h want %h", cal_opb, mk(6'd0, 32'd5, 32'd7)); end
        tick();
        @(negedge clk);
        n_cmp++; if (wb_val !== 1'b1 || cal_val !== 1'b0) begin n_err++; $display("FAIL add_n2_wb: got wb_val=%b cal_val=%b want 1/0", wb_val, cal_val); end
        n_cmp++; if (wb_data !== 32'd12 || wb_rd !== 5'd3 || wb_wen !== 1'b1) begin n_err++; $display("FAIL add_n2_data: got data=%0d rd=%0d wen=%b want 12/3/1", wb_data, wb_rd, wb_wen); end
        tick();
        @(negedge clk);
        n_cmp++; if (wb_val !== 1'b0 || cal_val !== 1'b0 || de_rdy !== 1'b1) begin n_err++; $display("FAIL add_n3_idle: got wb=%b cal=%b de_rdy=%b want 0/0/1", wb_val, cal_val, de_rdy); end
        tick();
    endtask

    task automatic test_cal_stall();
        logic [OPB_W-1:0] op;
        do_reset();
        op = mk(6'd0, 32'hFFFF_FFFF, 32'd1);
        de_val = 1'b1; opb = op; rd = 5'd4; rd_wen = 1'b1; cal_rdy = 1'b0; wb_rdy = 1'b1;
        tick();
        de_val = 1'b0;
        for (int i = 0; i < 3; i++) begin
            opb = mk(6'd2, $urandom, $urandom);
            @(negedge clk);
            n_cmp++; if (cal_val !== 1'b1 || cal_opb !== op) begin n_err++; $display("FAIL cal_stall_hold[%0d]: got val=%b opb=%h want 1/%h", i, cal_val, cal_opb, op); end
            tick();
        end
        cal_rdy = 1'b1;
        tick();
        @(negedge clk);
        n_cmp++; if (wb_val !== 1'b1 || wb_data !== 32'h0) begin n_err++; $display("FAIL cal_stall_data: got val=%b data=%h want 1/00000000", wb_val, wb_data); end
        n_cmp++; if (stall_cnt !== 4'd3) begin n_err++; $display("FAIL cal_stall_cnt: got %0d want 3", stall_cnt); end
        tick();
    endtask

    task automatic test_wb_stall();
        do_reset();
        de_val = 1'b1; opb = mk(6'd1, 32'd100, 32'd58); rd = 5'd17; rd_wen = 1'b1; cal_rdy = 1'b1; wb_rdy = 1'b0;
        tick();
        tick();
        // decode keeps offering an operation that must not be taken
        opb = mk(6'd0, 32'd1, 32'd1); rd = 5'd2;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++; if (wb_val !== 1'b1 || wb_data !== 32'd42 || wb_rd !== 5'd17) begin n_err++; $display("FAIL wb_stall_hold[%0d]: got val=%b data=%0d rd=%0d want 1/42/17", i, wb_val, wb_data, wb_rd); end
            n_cmp++; if (de_rdy !== 1'b0) begin n_err++; $display("FAIL wb_stall_de_rdy[%0d]: got %b want 0", i, de_rdy); end
            tick();
        end
        de_val = 1'b0; wb_rdy = 1'b1;
        @(negedge clk);
        n_cmp++; if (de_rdy !== 1'b1 || wb_val !== 1'b1) begin n_err++; $display("FAIL wb_stall_release: got de_rdy=%b wb_val=%b want 1/1", de_rdy, wb_val); end
        tick();
        @(negedge clk);
        n_cmp++; if (wb_val !== 1'b0 || cal_val !== 1'b0 || stall_cnt !== 4'd2) begin n_err++; $display("FAIL wb_stall_end: got wb=%b cal=%b cnt=%0d want 0/0/2", wb_val, cal_val, stall_cnt); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [OPB_W-1:0] op_b;
        do_reset();
        op_b = mk(6'd2, 32'hF0F0_1234, 32'h0FF0_4321);
        de_val = 1'b1; opb = mk(6'd0, 32'd20, 32'd22); rd = 5'd1; rd_wen = 1'b1; cal_rdy = 1'b1; wb_rdy = 1'b1;
        tick();
        de_val = 1'b0;
        tick();
        de_val = 1'b1; opb = op_b; rd = 5'd2; rd_wen = 1'b1;
        @(negedge clk);
        n_cmp++; if (wb_val !== 1'b1 || wb_rd !== 5'd1 || wb_data !== 32'd42 || de_rdy !== 1'b1) begin n_err++; $display("FAIL b2b_a_retire: got wb=%b rd=%0d data=%0d de_rdy=%b want 1/1/42/1", wb_val, wb_rd, wb_data, de_rdy); end
        tick();
        de_val = 1'b0;
        @(negedge clk);
        n_cmp++; if (cal_val !== 1'b1 || cal_opb !== op_b || wb_val !== 1'b0 || de_rdy !== 1'b0) begin n_err++; $display("FAIL b2b_b_issue: got cal=%b opb=%h wb=%b de_rdy=%b want 1/%h/0/0", cal_val, cal_opb, wb_val, de_rdy, op_b); end
        tick();
        @(negedge clk);
        n_cmp++; if (wb_val !== 1'b1 || wb_rd !== 5'd2 || wb_data !== (32'hF0F0_1234 ^ 32'h0FF0_4321)) begin n_err++; $display("FAIL b2b_b_wb: got wb=%b rd=%0d data=%h want 1/2/%h", wb_val, wb_rd, wb_data, 32'hF0F0_1234 ^ 32'h0FF0_4321); end
        tick();
    endtask

    task automatic test_x0_dest();
        do_reset();
        de_val = 1'b1; opb = mk(6'd3, 32'hABCD_EF01, 32'hFF00_FF00); rd = 5'd0; rd_wen = 1'b1; cal_rdy = 1'b1; wb_rdy = 1'b0;
        tick();
        de_val = 1'b0;
        tick();
        @(negedge clk);
        n_cmp++; if (wb_val !== 1'b1 || wb_wen !== 1'b0 || wb_data !== 32'hAB00_EF00) begin n_err++; $display("FAIL x0_dest: got val=%b wen=%b data=%h want 1/0/ab00ef00", wb_val, wb_wen, wb_data); end
        wb_rdy = 1'b1;
        tick();
    endtask

    task automatic test_flush();
        do_reset();
        de_val = 1'b1; opb = mk(6'd0, 32'd1, 32'd2); rd = 5'd5; rd_wen = 1'b1; cal_rdy = 1'b1; wb_rdy = 1'b1;
        tick();
        flush = 1'b1;
        @(negedge clk);
        n_cmp++; if (cal_val !== 1'b0 || wb_val !== 1'b0 || de_rdy !== 1'b0) begin n_err++; $display("FAIL flush_cycle: got cal=%b wb=%b de_rdy=%b want 0/0/0", cal_val, wb_val, de_rdy); end
        tick();
        flush = 1'b0; de_val = 1'b0;
        @(negedge clk);
        n_cmp++; if (cal_val !== 1'b0 || wb_val !== 1'b0 || de_rdy !== 1'b1) begin n_err++; $display("FAIL flush_idle: got cal=%b wb=%b de_rdy=%b want 0/0/1", cal_val, wb_val, de_rdy); end
        tick();
        @(negedge clk);
        n_cmp++; if (wb_val !== 1'b0 || stall_cnt !== 4'd0) begin n_err++; $display("FAIL flush_no_wb: got wb=%b cnt=%0d want 0/0", wb_val, stall_cnt); end
        tick();
    endtask

    task automatic test_saturation();
        do_reset();
        de_val = 1'b1; opb = mk(6'd0, 32'd3, 32'd4); rd = 5'd6; rd_wen = 1'b1; cal_rdy = 1'b0; wb_rdy = 1'b1;
        tick();
        de_val = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i == 10) begin
                @(negedge clk);
                n_cmp++; if (stall_cnt !== 4'd10) begin n_err++; $display("FAIL sat_mid: got %0d want 10", stall_cnt); end
            end
            tick();
        end
        @(negedge clk);
        n_cmp++; if (stall_cnt !== 4'd15 || cal_val !== 1'b1) begin n_err++; $display("FAIL sat_top: got cnt=%0d cal=%b want 15/1", stall_cnt, cal_val); end
        // reset mid-operation, with a flush and a ready cal unit: reset wins
        rst = 1'b1; flush = 1'b1; cal_rdy = 1'b1;
        tick();
        rst = 1'b0; flush = 1'b0;
        @(negedge clk);
        n_cmp++; if (cal_val !== 1'b0 || wb_val !== 1'b0 || de_rdy !== 1'b1 || cal_opb !== '0 || stall_cnt !== 4'd0) begin n_err++; $display("FAIL rst_midop: got cal=%b wb=%b de_rdy=%b opb=%h cnt=%0d want 0/0/1/0/0", cal_val, wb_val, de_rdy, cal_opb, stall_cnt); end
        tick();
    endtask

    // Transaction-level model: tracks where the single in-flight operation is
    // (nowhere, at the calc unit, at writeback) and what it should produce.
    task automatic test_random();
        int               where;
        int               stalls;
        logic [OPB_W-1:0] c_opb;
        logic [4:0]       c_rd;
        logic             c_wen;
        logic             e_de;
        logic             e_cal;
        logic             e_wb;
        logic [CNT_W-1:0] e_cnt;
        do_reset();
        where = 0; stalls = 0; c_opb = '0; c_rd = '0; c_wen = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            de_val  = 1'($urandom_range(0, 1));
            cal_rdy = ($urandom_range(0, 3) != 0);
            wb_rdy  = ($urandom_range(0, 3) != 0);
            flush   = ($urandom_range(0, 19) == 0);
            opb     = mk(6'($urandom_range(0, 3)), $urandom, $urandom);
            rd      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            rd_wen  = 1'($urandom_range(0, 1));
            @(negedge clk);
            e_de  = !flush && (where == 0 || (where == 2 && wb_rdy));
            e_cal = !flush && where == 1;
            e_wb  = !flush && where == 2;
            e_cnt = (stalls > 15) ? 4'd15 : 4'(stalls);
            n_cmp++; if ({de_rdy, cal_val, wb_val} !== {e_de, e_cal, e_wb}) begin n_err++; $display("FAIL rnd_hs[%0d]: got de/cal/wb=%b%b%b want %b%b%b", i, de_rdy, cal_val, wb_val, e_de, e_cal, e_wb); end
            n_cmp++; if (stall_cnt !== e_cnt) begin n_err++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", i, stall_cnt, e_cnt); end
            if (where == 1) begin
                n_cmp++; if (cal_opb !== c_opb) begin n_err++; $display("FAIL rnd_opb[%0d]: got %h want %h", i, cal_opb, c_opb); end
            end
            if (e_wb) begin
                n_cmp++; if (wb_data !== calc(c_opb) || wb_rd !== c_rd || wb_wen !== (c_wen && c_rd != 5'd0)) begin n_err++; $display("FAIL rnd_wb[%0d]: got data=%h rd=%0d wen=%b want %h/%0d/%b", i, wb_data, wb_rd, wb_wen, calc(c_opb), c_rd, c_wen && c_rd != 5'd0); end
            end
            if (flush) begin
                where = 0;
            end else begin
                if ((where == 1 && !cal_rdy) || (where == 2 && !wb_rdy)) stalls++;
                if (where == 1 && cal_rdy) where = 2;
                else if (where == 2 && wb_rdy) where = 0;
                if (de_val && e_de) begin
                    c_opb = opb; c_rd = rd; c_wen = rd_wen; where = 1;
                end
            end
            tick();
        end
        flush = 1'b0; de_val = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_cal_stall();
        test_wb_stall();
        test_back_to_back();
        test_x0_dest();
        test_flush();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
